div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1 bit: request a division with the current operands.
REQ-005 SHALL have port is_signed, input, 1 bit: 1 = two's-complement (div), 0 = unsigned (divu).
REQ-006 SHALL have port dividend, input, WIDTH bits: numerator.
REQ-007 SHALL have port divisor, input, WIDTH bits: denominator.
REQ-008 SHALL have port cancel, input, 1 bit: abort the division in progress (pipeline flush/exception).
REQ-009 SHALL have port busy, output, 1 bit: division in progress; the pipeline stalls on it.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse; quotient/remainder valid.
REQ-011 SHALL have port quotient, output, WIDTH bits: registered; feeds the LO write-back select.
REQ-012 SHALL have port remainder, output, WIDTH bits: registered; feeds the HI write-back select.
REQ-013 SHALL have port div_by_zero, output, 1 bit: registered flag for the last completed operation.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE.
REQ-015 SHALL, when start=1 and cancel=0 in IDLE or DONE, latch is_signed, dividend and divisor at that edge.
REQ-016 SHALL, on that accepting edge, enter CALC with an iteration counter of WIDTH, or enter DONE at the next edge if divisor==0.
REQ-017 SHALL in CALC perform restoring division, 1 quotient bit per cycle, MSB first, on unsigned magnitudes.
REQ-018 SHALL use a WIDTH+1-bit partial-remainder subtract, so no carry is lost.
REQ-019 SHALL move from CALC to DONE after exactly WIDTH cycles; done is high at cycle WIDTH+1 after the start edge.
REQ-020 SHALL hold busy=1 in every CALC cycle and busy=0 in IDLE and DONE.
REQ-021 SHALL assert done only in DONE and return to IDLE afterwards unless a new start is accepted.
REQ-022 SHALL update quotient, remainder and div_by_zero only on entry to DONE, and hold them until the next DONE entry.
REQ-023 SHALL ignore start while in CALC.
REQ-024 SHALL on cancel=1 in CALC go to IDLE at the next edge, with no done pulse and outputs unchanged.
REQ-025 SHALL give cancel priority over start when both are high.
REQ-026 SHALL on divisor==0 set quotient to all ones, remainder = dividend and div_by_zero=1, for either signedness.
REQ-027 SHALL in signed mode negate the quotient when the operand signs differ.
REQ-028 SHALL in signed mode give the remainder the sign of the dividend.
REQ-029 SHALL return quotient = 0x80000000 and remainder = 0 for the signed overflow case 0x80000000 / 0xFFFFFFFF (WIDTH=32), with no flag.

Reset
REQ-030 SHALL, while rst_n=0 and independent of clk, force state IDLE, counter 0, busy=0, done=0, quotient=0, remainder=0 and div_by_zero=0.
REQ-031 SHALL discard an operation interrupted by reset; after release, the first start is accepted normally.

Configuration
REQ-032 SHALL, with macro DIV_SIGNED_EN defined, honour is_signed as specified in REQ-026 to REQ-029.
REQ-033 SHALL, without DIV_SIGNED_EN, ignore is_signed, treat every operation as unsigned and omit the sign-correction logic.

Verification
REQ-034 SHALL cover: unsigned 100/7 -> quotient=14, remainder=2, done pulse exactly 33 cycles after start, busy high for 32 cycles.
REQ-035 SHALL cover: signed 0xFFFFFFF9/2 (-7/2) with DIV_SIGNED_EN -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; without the macro -> quotient=0x7FFFFFFC, remainder=1.
REQ-036 SHALL cover: 5/0 -> done one cycle after start, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, busy never high.
REQ-037 SHALL cover: signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_by_zero=0.
REQ-038 SHALL cover: cancel in CALC cycle 10 -> busy=0 next cycle, no done, outputs keep the previous results; start held during CALC -> ignored.
REQ-039 SHALL cover: rst_n low mid-CALC -> all outputs 0 immediately; after release, 9/3 -> quotient=3, remainder=0.

Source files
------------

// File: rtl/div_unit.sv
// Multi-cycle restoring divider: one quotient bit per cycle, MSB first.
// Define DIV_SIGNED_EN to honour is_signed; otherwise every operation is unsigned.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;

  logic             accept;
  logic             sgn_in;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   sub;
  logic             ge;
  logic [WIDTH:0]   rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;
  logic             unused_bits;

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  assign sgn_in      = is_signed;
  assign unused_bits = rem[WIDTH];
`else
  assign sgn_in      = 1'b0;
  assign unused_bits = rem[WIDTH] ^ is_signed;
`endif

  assign accept = start && !cancel && (state != CALC);
  assign busy   = (state == CALC);
  assign done   = (state == DONE);

  always_comb begin
    dvd_abs = dividend;
    dvs_abs = divisor;
    if (sgn_in && dividend[WIDTH-1]) dvd_abs = '0 - dividend;
    if (sgn_in && divisor[WIDTH-1])  dvs_abs = '0 - divisor;
  end

  // The quotient register doubles as the dividend shift register: its MSB
  // feeds the partial remainder while the new quotient bit enters at the LSB.
  always_comb begin
    shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
    sub     = shifted - {1'b0, dvs};
    ge      = (shifted >= {1'b0, dvs});
    rem_nx  = ge ? sub : shifted;
    quo_nx  = {quo[WIDTH-2:0], ge};
  end

  always_comb begin
    q_fin = quo_nx;
    r_fin = rem_nx[WIDTH-1:0];
`ifdef DIV_SIGNED_EN
    if (neg_q) q_fin = '0 - quo_nx;
    if (neg_r) r_fin = '0 - rem_nx[WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        CALC: begin
          if (cancel) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            rem <= rem_nx;
            quo <= quo_nx;
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
              state       <= DONE;
              quotient    <= q_fin;
              remainder   <= r_fin;
              div_by_zero <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          if (accept) begin
            rem <= '0;
            quo <= dvd_abs;
            dvs <= dvs_abs;
`ifdef DIV_SIGNED_EN
            neg_q <= sgn_in && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r <= sgn_in && dividend[WIDTH-1];
`endif
            if (divisor == '0) begin
              state       <= DONE;
              cnt         <= '0;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= CALC;
              cnt   <= CW'(WIDTH);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Randomized self-checking bench for div_unit against an arithmetic reference model.
module tb_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         cancel = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;
  logic         last_z = 1'b0;

  div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .cancel(cancel),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division; C-style truncation for signed mode.
  task automatic model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    longint sa, sb, sq, sr;
    logic   use_sgn;
`ifdef DIV_SIGNED_EN
    use_sgn = sgn;
`else
    use_sgn = 1'b0;
`endif
    z = (b == '0);
    if (z) begin
      q = '1;
      r = a;
    end else if (use_sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sq = sa / sb;
      sr = sa % sb;
      q = sq[W-1:0];
      r = sr[W-1:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  task automatic run_op(input string tag, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic hold);
    logic [W-1:0] eq, er;
    logic         ez;
    int           cyc, bc;
    model(sgn, a, b, eq, er, ez);
    @(negedge clk);
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    cyc = 0;
    bc  = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (busy) bc++;
      if (done) break;
      if (hold) begin
        is_signed = ~sgn;
        dividend  = $urandom;
        divisor   = $urandom;
      end
    end
    start = 1'b0;
    check({tag, " done_cycle"}, 64'(cyc), ez ? 64'd1 : 64'(W + 1));
    check({tag, " busy_cycles"}, 64'(bc), ez ? 64'd0 : 64'(W));
    check({tag, " quotient"}, 64'(quotient), 64'(eq));
    check({tag, " remainder"}, 64'(remainder), 64'(er));
    check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(ez));
    @(negedge clk);
    check({tag, " done_pulse"}, 64'(done), 64'd0);
    last_q = eq;
    last_r = er;
    last_z = ez;
  endtask

  initial begin
    logic [W-1:0] a, b;
    int           dn, cyc;

    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset outputs", {31'd0, div_by_zero, quotient}, 64'd0);
    check("reset rem", 64'(remainder), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_op("u100_7", 1'b0, 32'd100, 32'd7, 1'b0);
    run_op("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("u5_0", 1'b0, 32'd5, 32'd0, 1'b0);
    run_op("s5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 1'b0);
    run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("u_max", 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op("hold_start", 1'b0, 32'd123456, 32'd789, 1'b1);

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: b = -W'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op("rand", 1'($urandom_range(0, 1)), a, b, 1'b0);
    end

    // Cancel during the tenth CALC cycle.
    @(negedge clk);
    is_signed = 1'b0;
    dividend  = 32'd1000;
    divisor   = 32'd3;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    @(negedge clk);
    check("cancel busy", 64'(busy), 64'd0);
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("cancel no_done", 64'(dn), 64'd0);
    check("cancel quotient", 64'(quotient), 64'(last_q));
    check("cancel remainder", 64'(remainder), 64'(last_r));
    check("cancel dbz", 64'(div_by_zero), 64'(last_z));

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    dividend = 32'd77;
    divisor  = 32'd5;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst quotient", 64'(quotient), 64'd0);
    check("rst remainder", 64'(remainder), 64'd0);
    check("rst dbz", 64'(div_by_zero), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst 9_3", 1'b0, 32'd9, 32'd3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
